slingshot_launcher: RTL and testbench

Player-facing launch controller that sits directly upstream of the bird motion block. It reads the pull and aim keys, charges a launch power level over video frames, and converts power and angle into initial X/Y speeds. It then issues a single-cycle fire pulse and tracks the flight handshake (`shoot`) so that no new launch is armed until the bird has landed and a cooldown has expired.

---
 rtl/launcher_pkg.sv | 43 ++++
 rtl/key_edge_det.sv | 25 ++
 rtl/slingshot_launcher.sv | 205 ++++++++++++++++++++
 tb/tb_slingshot_launcher.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/launcher_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | launcher_pkg                                                          |
// | Shared constants for the slingshot launcher: FSM state codes, the     |
// | aim-angle speed factor tables and the speed scaling helper.           |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package launcher_pkg;

  // FSM state encoding
  localparam logic [2:0] c_IDLE       = 3'd0;
  localparam logic [2:0] c_CHARGE     = 3'd1;
  localparam logic [2:0] c_FIRE       = 3'd2;
  localparam logic [2:0] c_WAIT_SHOOT = 3'd3;
  localparam logic [2:0] c_FLIGHT     = 3'd4;
  localparam logic [2:0] c_COOLDOWN   = 3'd5;

  // Angle factor tables, 4 bits per entry, entry 0 in the low nibble.
  // idx0 (8,0)  idx1 (7,3)  idx2 (6,5)  idx3 (4,7)
  localparam logic [15:0] c_XF_TABLE = {4'd4, 4'd6, 4'd7, 4'd8};
  localparam logic [15:0] c_YF_TABLE = {4'd7, 4'd5, 4'd3, 4'd0};

  // Speed units are 1/64 px per frame; power*factor is scaled by this
  localparam int c_SPEED_SCALE = 4;

  function automatic logic [3:0] angle_xf(input logic [1:0] idx);
    return c_XF_TABLE[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] angle_yf(input logic [1:0] idx);
    return c_YF_TABLE[{idx, 2'b00} +: 4];
  endfunction

  // Largest result is 15*8*4 = 480, so 11 bits never overflow
  function automatic logic [10:0] speed_mag(input logic [3:0] power,
                                            input logic [3:0] factor);
    logic [10:0] w_prod;
    w_prod = 11'(power) * 11'(factor);
    return w_prod * 11'(c_SPEED_SCALE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge_det.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | key_edge_det                                                          |
// | Single-register rising-edge detector for a level key input.           |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module key_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_rise
);

  logic r_key_d;

  // Delayed copy of the key for edge comparison
  always_ff @(posedge clk) begin
    if (rst) r_key_d <= 1'b0;
    else     r_key_d <= i_key;
  end

  assign o_rise = i_key & ~r_key_d;

endmodule
`default_nettype wire

// File: rtl/slingshot_launcher.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | slingshot_launcher                                                    |
// | Charges launch power over video frames, aims, latches initial X/Y     |
// | speeds, issues a one-cycle fire pulse and blocks re-arming until the  |
// | bird has landed and a cooldown has elapsed.                           |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module slingshot_launcher #(
  parameter int MIN_POWER           = 2,
  parameter int MAX_POWER           = 15,
  parameter int CHARGE_FRAMES       = 4,
  parameter int COOLDOWN_FRAMES     = 30,
  parameter int FIRE_TIMEOUT_FRAMES = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               pull_key,
  input  logic               aim_up_key,
  input  logic               aim_down_key,
  input  logic               bird_in_flight,
  input  logic               levelChange,
  output logic        [10:0] initial_x_speed,
  output logic signed [10:0] initial_y_speed,
  output logic               Fire_The_Bird,
  output logic        [3:0]  power_level,
  output logic        [1:0]  angle_idx,
  output logic               launcher_ready
);

  import launcher_pkg::*;

  // One shared frame counter sized for the longest count
  localparam int c_CNT_MAX_A = (CHARGE_FRAMES > FIRE_TIMEOUT_FRAMES) ? CHARGE_FRAMES
                                                                     : FIRE_TIMEOUT_FRAMES;
  localparam int c_CNT_MAX   = (c_CNT_MAX_A > COOLDOWN_FRAMES) ? c_CNT_MAX_A : COOLDOWN_FRAMES;
  localparam int c_CNT_W     = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_CHARGE_LAST   = c_CNT_W'(CHARGE_FRAMES - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST  = c_CNT_W'(FIRE_TIMEOUT_FRAMES - 1);
  localparam logic [c_CNT_W-1:0] c_COOLDOWN_LAST = c_CNT_W'(COOLDOWN_FRAMES - 1);

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_power;
  logic [1:0]         r_angle;
  logic [10:0]        r_x;
  logic signed [10:0] r_y;
  logic               r_fire;
  logic               r_ready;

  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [3:0]         w_power_nxt;
  logic [1:0]         w_angle_nxt;
  logic [10:0]        w_x_nxt;
  logic signed [10:0] w_y_nxt;
  logic               w_aim_en;
  logic               w_pull_rise;
  logic               w_up_rise;
  logic               w_down_rise;

  key_edge_det u_pull_edge (
    .clk    (clk),
    .rst    (resetN),
    .i_key  (pull_key),
    .o_rise (w_pull_rise)
  );

  key_edge_det u_up_edge (
    .clk    (clk),
    .rst    (resetN),
    .i_key  (aim_up_key),
    .o_rise (w_up_rise)
  );

  key_edge_det u_down_edge (
    .clk    (clk),
    .rst    (resetN),
    .i_key  (aim_down_key),
    .o_rise (w_down_rise)
  );

  // Next-state, counter, power, aim and speed-latch decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_power_nxt = r_power;
    w_angle_nxt = r_angle;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_aim_en    = 1'b0;

    if (levelChange) begin
      // Abort wins over everything; aim and latched speeds survive
      w_state_nxt = c_IDLE;
      w_cnt_nxt   = '0;
      w_power_nxt = 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          w_aim_en = 1'b1;
          if (w_pull_rise) begin
            w_state_nxt = c_CHARGE;
            w_power_nxt = 4'(MIN_POWER);
            w_cnt_nxt   = '0;
          end
        end
        c_CHARGE: begin
          w_aim_en = 1'b1;
          if (!pull_key) begin
            // Latch uses the power/angle currently shown on the HUD
            w_state_nxt = c_FIRE;
            w_x_nxt     = speed_mag(r_power, angle_xf(r_angle));
            w_y_nxt     = $signed(11'd0 - speed_mag(r_power, angle_yf(r_angle)));
          end else if (startOfFrame) begin
            if (r_cnt == c_CHARGE_LAST) begin
              w_cnt_nxt = '0;
              if (r_power < 4'(MAX_POWER)) w_power_nxt = r_power + 4'd1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        c_FIRE: begin
          w_state_nxt = c_WAIT_SHOOT;
          w_cnt_nxt   = '0;
        end
        c_WAIT_SHOOT: begin
          if (bird_in_flight) begin
            w_state_nxt = c_FLIGHT;
          end else if (startOfFrame) begin
            // No flight handshake: the motion block rejected the shot
            if (r_cnt == c_TIMEOUT_LAST) begin
              w_state_nxt = c_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        c_FLIGHT: begin
          if (!bird_in_flight) begin
            w_state_nxt = c_COOLDOWN;
            w_cnt_nxt   = '0;
          end
        end
        c_COOLDOWN: begin
          if (startOfFrame) begin
            if (r_cnt == c_COOLDOWN_LAST) begin
              w_state_nxt = c_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase

      // Opposing edges in the same cycle cancel out
      if (w_aim_en && w_up_rise && !w_down_rise && r_angle != 2'd3)
        w_angle_nxt = r_angle + 2'd1;
      else if (w_aim_en && w_down_rise && !w_up_rise && r_angle != 2'd0)
        w_angle_nxt = r_angle - 2'd1;
    end
  end

  // State and output registers; fire pulses the cycle after FIRE so the
  // speeds latched on entry to FIRE lead the pulse by one cycle
  always_ff @(posedge clk) begin
    if (resetN) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_power <= 4'd0;
      r_angle <= 2'd1;
      r_x     <= 11'd0;
      r_y     <= 11'sd0;
      r_fire  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_power <= w_power_nxt;
      r_angle <= w_angle_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_fire  <= (r_state == c_FIRE) && !levelChange;
      r_ready <= (w_state_nxt == c_IDLE);
    end
  end

  assign initial_x_speed = r_x;
  assign initial_y_speed = r_y;
  assign Fire_The_Bird   = r_fire;
  assign power_level     = r_power;
  assign angle_idx       = r_angle;
  assign launcher_ready  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_slingshot_launcher.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_slingshot_launcher                                                 |
// | Directed self-checking bench for slingshot_launcher.                  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_slingshot_launcher;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               pull_key;
  logic               aim_up_key;
  logic               aim_down_key;
  logic               bird_in_flight;
  logic               levelChange;
  logic        [10:0] initial_x_speed;
  logic signed [10:0] initial_y_speed;
  logic               Fire_The_Bird;
  logic        [3:0]  power_level;
  logic        [1:0]  angle_idx;
  logic               launcher_ready;

  int n_checks = 0;
  int n_fails  = 0;

  slingshot_launcher dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .pull_key        (pull_key),
    .aim_up_key      (aim_up_key),
    .aim_down_key    (aim_down_key),
    .bird_in_flight  (bird_in_flight),
    .levelChange     (levelChange),
    .initial_x_speed (initial_x_speed),
    .initial_y_speed (initial_y_speed),
    .Fire_The_Bird   (Fire_The_Bird),
    .power_level     (power_level),
    .angle_idx       (angle_idx),
    .launcher_ready  (launcher_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) begin
      aim_up_key = 1'b1;
      tick();
      aim_up_key = 1'b0;
      tick();
    end
  endtask

  task automatic press_down(input int n);
    for (int i = 0; i < n; i++) begin
      aim_down_key = 1'b1;
      tick();
      aim_down_key = 1'b0;
      tick();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b1; startOfFrame = 1'b0; pull_key = 1'b0; aim_up_key = 1'b0;
    aim_down_key = 1'b0; bird_in_flight = 1'b0; levelChange = 1'b0;
    tick(); tick();
    resetN = 1'b0;

    // Reset values
    check_eq("rst_x",     initial_x_speed, 0);
    check_eq("rst_y",     32'($signed(initial_y_speed)), 0);
    check_eq("rst_fire",  Fire_The_Bird, 0);
    check_eq("rst_power", power_level, 0);
    check_eq("rst_angle", angle_idx, 1);
    check_eq("rst_ready", launcher_ready, 1);

    // Charge 12 frames at idx1: power 2 -> 5, X=5*7*4, Y=-(5*3*4)
    pull_key = 1'b1;
    tick();
    check_eq("chg_start_power", power_level, 2);
    check_eq("chg_ready_low",   launcher_ready, 0);
    frames(12);
    check_eq("chg_power_12f", power_level, 5);
    pull_key = 1'b0;
    tick();
    check_eq("latch_x",         initial_x_speed, 140);
    check_eq("latch_y",         32'($signed(initial_y_speed)), -60);
    check_eq("fire_not_yet",    Fire_The_Bird, 0);
    tick();
    check_eq("fire_pulse",      Fire_The_Bird, 1);
    check_eq("fire_x_hold",     initial_x_speed, 140);
    tick();
    check_eq("fire_one_cycle",  Fire_The_Bird, 0);

    // Full flight: 50 frames airborne, pull held throughout, cooldown 30 frames
    bird_in_flight = 1'b1;
    tick();
    pull_key = 1'b1;
    frames(50);
    check_eq("flight_ready",    launcher_ready, 0);
    check_eq("flight_x_hold",   initial_x_speed, 140);
    check_eq("flight_y_hold",   32'($signed(initial_y_speed)), -60);
    bird_in_flight = 1'b0;
    tick();
    frames(29);
    check_eq("cool_29_ready",   launcher_ready, 0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check_eq("cool_30_ready",   launcher_ready, 1);
    tick(); tick(); tick();
    check_eq("held_pull_ready", launcher_ready, 1);
    check_eq("held_pull_power", power_level, 5);
    pull_key = 1'b0;
    tick();

    // Angle saturation and simultaneous edges
    press_up(5);
    check_eq("angle_up_sat",   angle_idx, 3);
    press_down(5);
    check_eq("angle_down_sat", angle_idx, 0);
    aim_up_key = 1'b1; aim_down_key = 1'b1;
    tick();
    aim_up_key = 1'b0; aim_down_key = 1'b0;
    tick();
    check_eq("angle_both",     angle_idx, 0);

    // Power saturation at idx0, then fire timeout with no flight handshake
    pull_key = 1'b1;
    tick();
    frames(100);
    check_eq("sat_power", power_level, 15);
    pull_key = 1'b0;
    tick();
    check_eq("sat_x", initial_x_speed, 480);
    check_eq("sat_y", 32'($signed(initial_y_speed)), 0);
    tick();
    check_eq("sat_fire", Fire_The_Bird, 1);
    tick();
    frames(1);
    check_eq("timeout_1f_ready", launcher_ready, 0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check_eq("timeout_2f_ready", launcher_ready, 1);
    tick();

    // Abort during charge; release in the same cycle must not latch
    pull_key = 1'b1;
    tick();
    frames(5);
    check_eq("abort_pre_power", power_level, 3);
    levelChange = 1'b1; pull_key = 1'b0;
    tick();
    levelChange = 1'b0;
    check_eq("abort_power", power_level, 0);
    check_eq("abort_ready", launcher_ready, 1);
    check_eq("abort_x_kept", initial_x_speed, 480);
    tick();
    check_eq("abort_no_fire1", Fire_The_Bird, 0);
    tick();
    check_eq("abort_no_fire2", Fire_The_Bird, 0);

    // Reset in the middle of the fire pulse
    pull_key = 1'b1;
    tick();
    pull_key = 1'b0;
    tick();
    check_eq("mid_x", initial_x_speed, 64);
    tick();
    check_eq("mid_fire", Fire_The_Bird, 1);
    resetN = 1'b1;
    tick();
    resetN = 1'b0;
    check_eq("mid_rst_fire",  Fire_The_Bird, 0);
    check_eq("mid_rst_x",     initial_x_speed, 0);
    check_eq("mid_rst_power", power_level, 0);
    check_eq("mid_rst_angle", angle_idx, 1);
    check_eq("mid_rst_ready", launcher_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
